// File: rtl/fifo_stream_reader_pkg.sv
// Shared types for the CAPH FIFO read-side stream adapter.
// Holds the skid-buffer state encoding and the frame-counter width helper.
package fifo_stream_reader_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  // Frame counter needs at least one bit, even for frame_len of 1 or 2.
  function automatic int fcnt_width(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-slot skid buffer between a show-ahead FIFO and a valid/ready sink.
// Slot 0 drives the stream; slot 1 absorbs the token in flight while the sink stalls.
module fifo_rd_skid
  import fifo_stream_reader_pkg::*;
#(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic [size-1:0] din_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [size-1:0] data_o,
  output logic            full_o,
  output logic            pop_o
);

  buf_state_t      cnt_q, cnt_d;
  logic [size-1:0] s0_q, s0_d;
  logic [size-1:0] s1_q, s1_d;
  logic            valid_q, valid_d;
  logic            pop;

  assign pop = valid_q && ready_i;

  always_comb begin
    cnt_d = cnt_q;
    s0_d  = s0_q;
    s1_d  = s1_q;
    case (cnt_q)
      EMPTY: begin
        if (push_i) begin
          cnt_d = ONE;
          s0_d  = din_i;
        end
      end
      ONE: begin
        // Head drained this cycle, so the new token lands straight in slot 0.
        if (push_i && pop) begin
          s0_d = din_i;
        end else if (push_i) begin
          cnt_d = FULL;
          s1_d  = din_i;
        end else if (pop) begin
          cnt_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          cnt_d = ONE;
          s0_d  = s1_q;
        end
      end
      default: cnt_d = EMPTY;
    endcase
    valid_d = (cnt_d != EMPTY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= EMPTY;
      s0_q    <= '0;
      s1_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = s0_q;
  assign full_o  = (cnt_q == FULL);
  assign pop_o   = pop;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a show-ahead CAPH FIFO onto a valid/ready stream through a 2-entry skid buffer.
// Define FIFO_STREAM_READER_LAST_EN to enable the frame counter driving out_last_o.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int size      = 8,
  parameter int frame_len = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fifo_empty_i,
  input  logic [size-1:0] fifo_dout_i,
  output logic            fifo_enr_o,
  output logic [size-1:0] out_data_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic            out_last_o
);

  logic full;
  logic pop;

  // Depends only on the FIFO flag and registered buffer state: out_ready never reaches it.
  assign fifo_enr_o = rst && !fifo_empty_i && !full;

  fifo_rd_skid #(.size(size)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_enr_o),
    .din_i   (fifo_dout_i),
    .ready_i (out_ready_i),
    .valid_o (out_valid_o),
    .data_o  (out_data_o),
    .full_o  (full),
    .pop_o   (pop)
  );

`ifdef FIFO_STREAM_READER_LAST_EN
  localparam int            FW   = fcnt_width(frame_len);
  localparam logic [FW-1:0] FMAX = FW'(frame_len - 1);

  logic [FW-1:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    if (pop) fcnt_d = (fcnt_q == FMAX) ? '0 : fcnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fcnt_q <= '0;
    else      fcnt_q <= fcnt_d;
  end

  assign out_last_o = out_valid_o && (fcnt_q == FMAX);
`else
  logic unused_cfg;
  assign unused_cfg = pop ^ (frame_len > 0);
  assign out_last_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a queue models the FIFO, a monitor checks the stream.
module tb_fifo_stream_reader;
  localparam int SZ = 8;
  localparam int FL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fifo_empty;
  logic [SZ-1:0] fifo_dout;
  logic          fifo_enr;
  logic [SZ-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  always #5 clk = ~clk;

  fifo_stream_reader #(.size(SZ), .frame_len(FL)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty_i (fifo_empty),
    .fifo_dout_i  (fifo_dout),
    .fifo_enr_o   (fifo_enr),
    .out_data_o   (out_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_last_o   (out_last)
  );

  int checks   = 0;
  int failures = 0;
  int npop     = 0;
  int viol     = 0;
  int idx      = 0;
  int nlast    = 0;
  logic [SZ-1:0] src_q[$];
  logic [SZ-1:0] exp_q[$];
  logic gate_empty = 1'b0;
  logic enr_s      = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic upd();
    fifo_empty = gate_empty || (src_q.size() == 0);
    fifo_dout  = (src_q.size() > 0) ? src_q[0] : '0;
  endtask

  task automatic push_tok(input logic [SZ-1:0] v);
    src_q.push_back(v);
    exp_q.push_back(v);
    upd();
  endtask

  task automatic wait_drain(input string nm, input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  // FIFO model: head consumed at an edge where the strobe was high.
  always @(negedge clk) enr_s = fifo_enr;
  always @(posedge clk) begin
    #1;
    if (enr_s && src_q.size() > 0) begin
      void'(src_q.pop_front());
      npop++;
    end
    upd();
  end

  // Monitor: compare every accepted token against the scoreboard.
  always @(negedge clk) begin
    logic [SZ-1:0] e;
    logic          el;
    if (!rst) begin
      idx = 0;
    end else begin
      if (fifo_enr && fifo_empty) viol++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_token", 32'(out_data), 32'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          chk("stream_data", 32'(out_data), 32'(e));
`ifdef FIFO_STREAM_READER_LAST_EN
          el = ((idx % FL) == FL - 1);
`else
          el = 1'b0;
`endif
          chk("stream_last", 32'(out_last), 32'(el));
          if (out_last) nlast++;
          idx++;
        end
      end
    end
  end

  initial begin
    int nv;
    int bad;
    int n0;
    int pushed;
    int cyc;
    out_ready = 1'b0;
    upd();

    // Reset state, with a token waiting so the strobe gating by reset is visible.
    push_tok(8'hAA);
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_enr", 32'(fifo_enr), 0);
    chk("rst_last", 32'(out_last), 0);
    src_q.delete();
    exp_q.delete();
    upd();
    @(posedge clk); #1;
    rst = 1'b1;

    // Streaming 0x01..0x08 with the sink always ready.
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push_tok(8'(i));
    @(negedge clk);
    chk("lat_enr", 32'(fifo_enr), 1);
    chk("lat_no_valid_yet", 32'(out_valid), 0);
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    chk("stream_consecutive", nv, 8);
    wait_drain("stream_drain", 20);

    // Stall for 10 cycles with the FIFO non-empty.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_tok(8'(8'h10 + i));
    @(negedge clk);
    n0  = npop;
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (out_valid && out_data !== 8'h10) bad++;
    end
    chk("stall_pops", npop - n0, 2);
    chk("stall_enr", 32'(fifo_enr), 0);
    chk("stall_valid", 32'(out_valid), 1);
    chk("stall_hold", bad, 0);
    chk("stall_data", 32'(out_data), 32'h10);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("stall_drain", 30);

    // Empty source for 20 cycles, then one token.
    @(posedge clk); #1;
    gate_empty = 1'b1;
    push_tok(8'h5A);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_enr || out_valid) bad++;
    end
    chk("empty_idle", bad, 0);
    @(posedge clk); #1;
    gate_empty = 1'b0;
    upd();
    @(negedge clk);
    chk("empty_fall_enr", 32'(fifo_enr), 1);
    chk("empty_fall_novalid", 32'(out_valid), 0);
    @(negedge clk);
    chk("empty_token_valid", 32'(out_valid), 1);
    chk("empty_token_data", 32'(out_data), 32'h5A);
    wait_drain("empty_drain", 10);

    // Reset with the buffer full: buffered tokens are discarded.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_tok(8'(8'h21 + i));
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_enr", 32'(fifo_enr), 0);
    chk("midrst_data", 32'(out_data), 0);
    chk("midrst_fifo_left", 32'(src_q.size()), 2);
    exp_q = src_q;
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_first_head", 32'(out_data), 32'h23);
    wait_drain("midrst_drain", 20);

    // Frame marking over 12 tokens with sink stalls; counter restarts at reset.
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst   = 1'b1;
    nlast = 0;
    for (int i = 0; i < 12; i++) push_tok(8'(8'h40 + i));
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
      out_ready = (i % 3) != 1;
    end
    chk("frame_drain", exp_q.size(), 0);
`ifdef FIFO_STREAM_READER_LAST_EN
    chk("frame_last_count", nlast, 3);
`else
    chk("frame_last_count", nlast, 0);
`endif

    // Random ready and empty over 1000 tokens.
    pushed = 0;
    cyc    = 0;
    while ((pushed < 1000 || exp_q.size() != 0) && cyc < 20000) begin
      @(posedge clk); #1;
      out_ready  = $urandom_range(0, 1) == 1;
      gate_empty = $urandom_range(0, 1) == 1;
      if (pushed < 1000 && src_q.size() < 4) begin
        push_tok(8'(pushed * 7 + 3));
        pushed++;
      end
      upd();
      cyc++;
    end
    chk("random_drain", exp_q.size(), 0);
    chk("random_pushed", pushed, 1000);
    chk("enr_while_empty", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
